// File: rtl/cla_response_checker_pkg.sv
// Shared types and default sizing for the CLA response checker.
// CHK_HALT_ON_FAIL_EN adds the HALT state to the FSM encoding.
package cla_response_checker_pkg;

   localparam int unsigned DEF_W     = 2;
   localparam int unsigned DEF_N_VEC = 4;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3
`ifdef CHK_HALT_ON_FAIL_EN
      ,
      ST_HALT  = 3'd4
`endif
   } chk_state_e;

endpackage

// File: rtl/cla_ref_model.sv
// Combinational golden carry-lookahead adder: (a, b, ci) -> expected carry and sum words.
module cla_ref_model #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] c_exp_c,
   output logic [W-1:0] s_exp_c
);

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   k;

   assign g    = a & b;
   assign p    = a ^ b;
   assign k[0] = ci;

   // k[i] is the carry into bit i; k[i+1] is the carry out of bit i
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign k[i+1]     = g[i] | (p[i] & k[i]);
      assign c_exp_c[i] = k[i+1];
      assign s_exp_c[i] = p[i] ^ k[i];
   end

endmodule

// File: rtl/cla_response_checker.sv
// Scores adder response vectors against a reference CLA and reports pass/fail counts.
// Optional CHK_HALT_ON_FAIL_EN: stop in HALT on the first mismatching vector.
module cla_response_checker
   import cla_response_checker_pkg::*;
#(
   parameter int unsigned W     = DEF_W,
   parameter int unsigned N_VEC = DEF_N_VEC,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             ci,
   input  logic [W-1:0]     c,
   input  logic [W-1:0]     s,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err,
   output logic [CNT_W-1:0] fail_idx
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VEC - 1);

   chk_state_e       state, state_nx;
   logic [CNT_W-1:0] idx, idx_nx;
   logic [CNT_W-1:0] pass_nx, fail_nx, fidx_nx;
   logic             err_nx;
   logic [W-1:0]     cap_a, cap_b, cap_c, cap_s;
   logic [W-1:0]     cap_a_nx, cap_b_nx, cap_c_nx, cap_s_nx;
   logic             cap_ci, cap_ci_nx;
   logic             in_ready_nx, busy_nx, done_nx;
   logic [W-1:0]     c_exp_c, s_exp_c;
   logic             mismatch_c;

   cla_ref_model #(.W(W)) u_ref (
      .a       (cap_a),
      .b       (cap_b),
      .ci      (cap_ci),
      .c_exp_c (c_exp_c),
      .s_exp_c (s_exp_c)
   );

   assign mismatch_c = (cap_c != c_exp_c) || (cap_s != s_exp_c);

   // Next-state, scoring and registered-output decode
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      pass_nx   = pass_cnt;
      fail_nx   = fail_cnt;
      err_nx    = err;
      fidx_nx   = fail_idx;
      cap_a_nx  = cap_a;
      cap_b_nx  = cap_b;
      cap_ci_nx = cap_ci;
      cap_c_nx  = cap_c;
      cap_s_nx  = cap_s;

      unique case (state)
         ST_IDLE, ST_DONE
`ifdef CHK_HALT_ON_FAIL_EN
         , ST_HALT
`endif
         : begin
            if (start) begin
               state_nx = ST_RUN;
               idx_nx   = '0;
               pass_nx  = '0;
               fail_nx  = '0;
               err_nx   = 1'b0;
               fidx_nx  = '0;
            end
         end
         ST_RUN: begin
            if (in_valid && in_ready) begin
               cap_a_nx  = a;
               cap_b_nx  = b;
               cap_ci_nx = ci;
               cap_c_nx  = c;
               cap_s_nx  = s;
               state_nx  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (mismatch_c) begin
               fail_nx = (fail_cnt == CNT_MAX) ? fail_cnt : fail_cnt + CNT_W'(1);
               if (!err) begin
                  err_nx  = 1'b1;
                  fidx_nx = idx;
               end
            end else begin
               pass_nx = (pass_cnt == CNT_MAX) ? pass_cnt : pass_cnt + CNT_W'(1);
            end
            idx_nx   = idx + CNT_W'(1);
            state_nx = (idx == LAST_IDX) ? ST_DONE : ST_RUN;
`ifdef CHK_HALT_ON_FAIL_EN
            if (mismatch_c && !err) state_nx = ST_HALT;
`endif
         end
         default: state_nx = ST_IDLE;
      endcase

      in_ready_nx = (state_nx == ST_RUN);
      done_nx     = (state_nx == ST_DONE);
      busy_nx     = (state_nx == ST_RUN) || (state_nx == ST_CHECK)
`ifdef CHK_HALT_ON_FAIL_EN
                    || (state_nx == ST_HALT)
`endif
                    ;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         idx      <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         err      <= 1'b0;
         fail_idx <= '0;
         cap_a    <= '0;
         cap_b    <= '0;
         cap_ci   <= 1'b0;
         cap_c    <= '0;
         cap_s    <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         pass_cnt <= pass_nx;
         fail_cnt <= fail_nx;
         err      <= err_nx;
         fail_idx <= fidx_nx;
         cap_a    <= cap_a_nx;
         cap_b    <= cap_b_nx;
         cap_ci   <= cap_ci_nx;
         cap_c    <= cap_c_nx;
         cap_s    <= cap_s_nx;
         in_ready <= in_ready_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

endmodule
